// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, inverse S-box table and InvSubBytes FSM states
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [7:0]   byte_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fsm_t;

  // Entry 0x00 sits in the most significant byte; one row per high nibble.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic byte_t inv_sbox_lookup(input byte_t a);
    return INV_SBOX[8*(255 - int'(a)) +: 8];
  endfunction

endpackage

// File: rtl/sbox_inv_sync.sv
// rtl/sbox_inv_sync.sv - 256x8 inverse S-box ROM with registered output (1-cycle latency)
module sbox_inv_sync
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] a,
  output logic [7:0] y
);

  // No reset so the table maps onto a block RAM.
  always_ff @(posedge clk) begin
    y <= inv_sbox_lookup(a);
  end

endmodule

// File: rtl/aes_inv_sub_bytes.sv
// rtl/aes_inv_sub_bytes.sv - sequenced InvSubBytes engine; AES_INV_SBOX_DUAL_EN selects two ROM read ports
module aes_inv_sub_bytes
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] state_in,
  output logic [127:0] state_out,
  output logic         busy,
  output logic         done
);

`ifdef AES_INV_SBOX_DUAL_EN
  localparam int LANES = 2;
`else
  localparam int LANES = 1;
`endif
  localparam logic [3:0] STEP     = 4'(LANES);
  localparam logic [3:0] LAST_IDX = 4'(16 - LANES);

  fsm_t       fsm;
  state_t     src;
  logic [3:0] issue_idx;
  logic [3:0] wr_idx;
  logic       wr_valid;
  byte_t      rom_a [LANES];
  byte_t      rom_y [LANES];

  for (genvar lane = 0; lane < LANES; lane++) begin : g_rom
    logic [3:0] rd_k;
    assign rd_k        = issue_idx + 4'(lane);
    assign rom_a[lane] = src[8*(15 - int'(rd_k)) +: 8];

    sbox_inv_sync u_rom (
      .clk (clk),
      .a   (rom_a[lane]),
      .y   (rom_y[lane])
    );
  end

  assign busy = (fsm != ST_IDLE);
  assign done = (fsm == ST_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm       <= ST_IDLE;
      src       <= '0;
      issue_idx <= '0;
      wr_idx    <= '0;
      wr_valid  <= 1'b0;
      state_out <= '0;
    end else begin
      // ROM data for the bytes issued last cycle lands one edge later.
      wr_valid <= (fsm == ST_ISSUE);
      wr_idx   <= issue_idx;
      if (wr_valid) begin
        for (int lane = 0; lane < LANES; lane++) begin
          state_out[8*(15 - int'(wr_idx) - lane) +: 8] <= rom_y[lane];
        end
      end

      case (fsm)
        ST_IDLE: begin
          if (start) begin
            src       <= state_in;
            issue_idx <= '0;
            fsm       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          issue_idx <= issue_idx + STEP;
          if (issue_idx == LAST_IDX) fsm <= ST_DRAIN;
        end
        ST_DRAIN: fsm <= ST_DONE;
        ST_DONE:  fsm <= ST_IDLE;
        default:  fsm <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_sub_bytes.sv
// tb/tb_aes_inv_sub_bytes.sv - self-checking bench for aes_inv_sub_bytes (honours AES_INV_SBOX_DUAL_EN)
module tb_aes_inv_sub_bytes;

`ifdef AES_INV_SBOX_DUAL_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 17;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] state_in;
  logic [127:0] state_out;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;
  vec_t vecs [5];

  aes_inv_sub_bytes dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .state_in  (state_in),
    .state_out (state_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Reference: S-box from GF(2^8) inversion plus the affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h00;
    if (a != 8'h00) begin
      for (int b = 1; b < 256; b++) begin
        if (gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
      end
    end
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] fwd_state(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = fwd_tab[s[127-8*k -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] inv_state(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = inv_tab[s[127-8*k -: 8]];
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 with the engine idle again.
  task automatic run_op(input logic [127:0] s, output logic [127:0] res, output int lat,
                        output int done_cnt, output bit busy_ok);
    start = 1'b1;
    state_in = s;
    @(posedge clk); #1;
    start = 1'b0;
    state_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    lat = -1; done_cnt = 0; busy_ok = 1'b1; res = '0;
    for (int c = 0; c <= LAT + 3; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (busy !== (c <= LAT)) busy_ok = 1'b0;
      if (done === 1'b1) begin
        done_cnt++;
        if (lat < 0) begin lat = c; res = state_out; end
      end
    end
  endtask

  initial begin
    logic [127:0] res, exp_a, exp_b, a_in, b_in, res_a, res_b;
    int lat, done_cnt, first, second;
    bit busy_ok;

    for (int i = 0; i < 256; i++) fwd_tab[i] = fwd_sbox(8'(i));
    for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);

    vecs[0] = '{128'h637C777BF26B6FC53001672BFED7AB76, 128'h000102030405060708090A0B0C0D0E0F};
    vecs[1] = '{128'h0, {16{8'h52}}};
    vecs[2] = '{fwd_state(128'h3243F6A8885A308D313198A2E0370734), 128'h3243F6A8885A308D313198A2E0370734};
    vecs[3] = '{{16{8'hFF}}, {16{8'h7D}}};
    vecs[4] = '{{16{8'h63}}, 128'h0};

    reset = 1'b1; start = 1'b0; state_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset state_out", state_out, 128'h0);
    check("reset busy", 128'(busy), 128'h0);
    check("reset done", 128'(done), 128'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i].din, res, lat, done_cnt, busy_ok);
      check($sformatf("vec%0d state_out", i), res, vecs[i].exp);
      check($sformatf("vec%0d latency", i), 128'(lat), 128'(LAT));
      check($sformatf("vec%0d done pulses", i), 128'(done_cnt), 128'd1);
      check($sformatf("vec%0d busy window", i), 128'(busy_ok), 128'd1);
    end

    for (int i = 0; i < 20; i++) begin
      a_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_op(a_in, res, lat, done_cnt, busy_ok);
      check($sformatf("rand%0d state_out", i), res, inv_state(a_in));
      check($sformatf("rand%0d latency", i), 128'(lat), 128'(LAT));
    end

    // Reset five cycles into ISSUE clears everything without a clock edge.
    start = 1'b1; state_in = vecs[0].din;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midreset state_out", state_out, 128'h0);
    check("midreset busy", 128'(busy), 128'h0);
    check("midreset done", 128'(done), 128'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_op(vecs[0].din, res, lat, done_cnt, busy_ok);
    check("postreset state_out", res, vecs[0].exp);
    check("postreset latency", 128'(lat), 128'(LAT));

    // start held high; state_in changes right after the first capture.
    a_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    b_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    exp_a = inv_state(a_in);
    exp_b = inv_state(b_in);
    start = 1'b1; state_in = a_in;
    @(posedge clk); #1;
    state_in = b_in;
    done_cnt = 0; first = -1; second = -1; res_a = '0; res_b = '0;
    for (int c = 0; c <= 2 * LAT + 6; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (done === 1'b1) begin
        done_cnt++;
        if (first < 0) begin first = c; res_a = state_out; end
        else if (second < 0) begin second = c; res_b = state_out; end
      end
    end
    start = 1'b0;
    check("held first result", res_a, exp_a);
    check("held first done", 128'(first), 128'(LAT));
    check("held second result", res_b, exp_b);
    check("held second done", 128'(second), 128'(2 * LAT + 2));
    check("held done pulses", 128'(done_cnt), 128'd2);

    first = 0;
    while (busy === 1'b1 && first < 100) begin
      @(posedge clk); #1;
      first++;
    end
    check("final idle", 128'(busy), 128'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
